// File: rtl/qupls_agen_mc_if.sv
// qupls_agen_mc_if: per-channel request and beat handshake bundle for qupls_agen_mc
interface qupls_agen_mc_if #(
  parameter int NCH   = 2,
  parameter int AWID  = 64,
  parameter int DISPW = 24,
  parameter int TAGW  = 8
);
  logic [NCH-1:0]       in_valid;
  logic [NCH-1:0]       in_ready;
  logic [2*NCH-1:0]     in_mode;
  logic [AWID*NCH-1:0]  in_a;
  logic [AWID*NCH-1:0]  in_b;
  logic [3*NCH-1:0]     in_sc;
  logic [DISPW*NCH-1:0] in_disp;
  logic [3*NCH-1:0]     in_size;
  logic [TAGW*NCH-1:0]  in_tag;
  logic [NCH-1:0]       out_valid;
  logic [NCH-1:0]       out_ready;
  logic [AWID*NCH-1:0]  out_addr;
  logic [TAGW*NCH-1:0]  out_tag;
  logic [NCH-1:0]       out_split;
  logic [NCH-1:0]       out_beat;
  logic [NCH-1:0]       out_last;
  modport master (
    output in_valid, in_mode, in_a, in_b, in_sc, in_disp, in_size, in_tag, out_ready,
    input  in_ready, out_valid, out_addr, out_tag, out_split, out_beat, out_last
  );
  modport slave (
    input  in_valid, in_mode, in_a, in_b, in_sc, in_disp, in_size, in_tag, out_ready,
    output in_ready, out_valid, out_addr, out_tag, out_split, out_beat, out_last
  );
endinterface

// File: rtl/qupls_agen_mc.sv
// qupls_agen_mc: multi-channel address generator emitting one beat per cache line touched
module qupls_agen_mc #(
  parameter int NCH       = 2,
  parameter int AWID      = 64,
  parameter int DISPW     = 24,
  parameter int LINE_BITS = 6,
  parameter int TAGW      = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             flush_i,
  qupls_agen_mc_if.slave   bus
);
  typedef enum logic [1:0] {IDLE, B0, B1} state_e;
  localparam int SW = LINE_BITS + 5;
  for (genvar g = 0; g < NCH; g++) begin : g_ch
    logic [1:0]       mode;
    logic [AWID-1:0]  a, b, ea_d, line_d;
    logic [2:0]       sc, sz;
    logic [DISPW-1:0] disp;
    logic [SW-1:0]    span;
    logic             split_d, last, acc;
    state_e           state_q;
    logic [AWID-1:0]  addr_q;
    logic [TAGW-1:0]  tag_q;
    logic             split_q;
    assign mode = bus.in_mode[2*g +: 2];
    assign a    = bus.in_a[AWID*g +: AWID];
    assign b    = bus.in_b[AWID*g +: AWID];
    assign sc   = bus.in_sc[3*g +: 3];
    assign disp = bus.in_disp[DISPW*g +: DISPW];
    // effective address, clamped size and line-crossing test for the incoming op
    always_comb begin
      sz      = bus.in_size[3*g +: 3] > 3'd4 ? 3'd4 : bus.in_size[3*g +: 3];
      ea_d    = mode == 2'b01 ? a + (b << sc) + {{(AWID-DISPW){disp[DISPW-1]}}, disp}
              : mode == 2'b10 ? a + b : '0;
      span    = SW'(ea_d[LINE_BITS-1:0]) + (SW'(1) << sz) - SW'(1);
      split_d = (mode == 2'b01 || mode == 2'b10) && span >= SW'(2**LINE_BITS);
      line_d  = {addr_q[AWID-1:LINE_BITS] + (AWID-LINE_BITS)'(1), {LINE_BITS{1'b0}}};
    end
    assign last = state_q == B1 || (state_q == B0 && !split_q);
    assign acc  = bus.in_valid[g] && bus.in_ready[g];
    assign bus.in_ready[g] = rst_ni && !flush_i && (state_q == IDLE || (last && bus.out_ready[g]));
    assign bus.out_valid[g] = state_q != IDLE;
    assign bus.out_addr[AWID*g +: AWID] = addr_q;
    assign bus.out_tag[TAGW*g +: TAGW] = tag_q;
    assign bus.out_split[g] = split_q;
    assign bus.out_beat[g] = state_q == B1;
    assign bus.out_last[g] = last;
    // load on accept; on a consumed split first beat, step the address to the next line
    always_ff @(posedge clk_i or negedge rst_ni)
      if (!rst_ni) begin
        state_q <= IDLE;
        addr_q  <= '0;
        tag_q   <= '0;
        split_q <= 1'b0;
      end else if (flush_i) state_q <= IDLE;
      else if (acc) begin
        state_q <= B0;
        addr_q  <= ea_d;
        tag_q   <= bus.in_tag[TAGW*g +: TAGW];
        split_q <= split_d;
      end else if (bus.out_ready[g] && state_q == B0 && split_q) begin
        state_q <= B1;
        addr_q  <= line_d;
      end else if (bus.out_ready[g] && state_q != IDLE) state_q <= IDLE;
  end
endmodule

// File: tb/tb_qupls_agen_mc.sv
// tb_qupls_agen_mc: random and directed checks of qupls_agen_mc against a beat-queue model
module tb_qupls_agen_mc;
  logic clk_i = 1'b0;
  logic rst_ni, flush_i;
  always #5 clk_i = ~clk_i;
  qupls_agen_mc_if bus();
  qupls_agen_mc dut (.clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i), .bus(bus));
  typedef struct {
    logic [63:0] addr;
    logic [7:0]  tag;
    bit          split;
    bit          beat;
    bit          last;
  } beat_t;
  beat_t mq[2][$];
  int checks = 0, errors = 0;
  logic [7:0] tag_n[2];
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic set_op(input int c, input logic v, input logic [1:0] m, input logic [63:0] a,
                        input logic [63:0] b, input logic [2:0] sc, input logic [23:0] d,
                        input logic [2:0] sz);
    bus.in_valid[c] = v;
    bus.in_mode[c*2 +: 2] = m;
    bus.in_a[c*64 +: 64] = a;
    bus.in_b[c*64 +: 64] = b;
    bus.in_sc[c*3 +: 3] = sc;
    bus.in_disp[c*24 +: 24] = d;
    bus.in_size[c*3 +: 3] = sz;
    bus.in_tag[c*8 +: 8] = tag_n[c];
    tag_n[c] = tag_n[c] + 8'd1;
  endtask
  function automatic void ref_op(input logic [1:0] m, input logic [63:0] a, input logic [63:0] b,
                                 input logic [2:0] sc, input logic [23:0] d, input logic [2:0] sz,
                                 output logic [63:0] ad, output bit sp);
    int n;
    ad = m == 2'b01 ? a + b * (64'd1 << sc) + 64'($signed(d)) : m == 2'b10 ? a + b : 64'd0;
    n  = 1 << (sz > 3'd4 ? 4 : int'(sz));
    sp = (m == 2'b01 || m == 2'b10) && (int'(ad % 64) + n - 1 >= 64);
  endfunction
  task automatic model_check;
    for (int c = 0; c < 2; c++) begin
      bit e;
      chk($sformatf("valid%0d", c), 64'(bus.out_valid[c]), 64'(mq[c].size() != 0));
      if (mq[c].size() != 0) begin
        chk($sformatf("addr%0d", c), bus.out_addr[c*64 +: 64], mq[c][0].addr);
        chk($sformatf("tag%0d", c), 64'(bus.out_tag[c*8 +: 8]), 64'(mq[c][0].tag));
        chk($sformatf("split%0d", c), 64'(bus.out_split[c]), 64'(mq[c][0].split));
        chk($sformatf("beat%0d", c), 64'(bus.out_beat[c]), 64'(mq[c][0].beat));
        chk($sformatf("last%0d", c), 64'(bus.out_last[c]), 64'(mq[c][0].last));
      end
      e = !flush_i && (mq[c].size() == 0 || (mq[c].size() == 1 && bus.out_ready[c]));
      chk($sformatf("ready%0d", c), 64'(bus.in_ready[c]), 64'(e));
    end
  endtask
  task automatic model_update;
    for (int c = 0; c < 2; c++) begin
      bit rdy, sp;
      logic [63:0] ad;
      rdy = !flush_i && (mq[c].size() == 0 || (mq[c].size() == 1 && bus.out_ready[c]));
      if (mq[c].size() != 0 && bus.out_ready[c]) void'(mq[c].pop_front());
      if (flush_i) mq[c].delete();
      else if (bus.in_valid[c] && rdy) begin
        ref_op(bus.in_mode[c*2 +: 2], bus.in_a[c*64 +: 64], bus.in_b[c*64 +: 64],
               bus.in_sc[c*3 +: 3], bus.in_disp[c*24 +: 24], bus.in_size[c*3 +: 3], ad, sp);
        mq[c].push_back('{ad, bus.in_tag[c*8 +: 8], sp, 1'b0, !sp});
        if (sp) mq[c].push_back('{((ad >> 6) + 64'd1) << 6, bus.in_tag[c*8 +: 8], 1'b1, 1'b1, 1'b1});
      end
    end
  endtask
  task automatic step;
    #1 model_check();
    @(posedge clk_i);
    model_update();
    @(negedge clk_i);
  endtask
  initial begin
    rst_ni = 1'b0;
    flush_i = 1'b0;
    bus.in_valid = '0;
    bus.in_mode = '0;
    bus.in_a = '0;
    bus.in_b = '0;
    bus.in_sc = '0;
    bus.in_disp = '0;
    bus.in_size = '0;
    bus.in_tag = '0;
    bus.out_ready = '0;
    tag_n[0] = 8'h10;
    tag_n[1] = 8'h80;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    chk("rst_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_ready", 64'(bus.in_ready), 64'd0);
    chk("rst_addr", bus.out_addr[63:0], 64'd0);
    chk("rst_tag", 64'(bus.out_tag), 64'd0);
    chk("rst_flags", 64'({bus.out_split, bus.out_beat, bus.out_last}), 64'd0);
    rst_ni = 1'b1;
    set_op(0, 1'b1, 2'b01, 64'h1000, 64'h10, 3'd3, 24'hFFFFF8, 3'd3);
    bus.out_ready = 2'b11;
    step();
    bus.in_valid = '0;
    chk("t1_addr", bus.out_addr[63:0], 64'h1078);
    chk("t1_split", 64'(bus.out_split[0]), 64'd0);
    chk("t1_last", 64'(bus.out_last[0]), 64'd1);
    step();
    bus.out_ready = 2'b00;
    set_op(0, 1'b1, 2'b01, 64'h103C, 64'd0, 3'd0, 24'd0, 3'd3);
    step();
    bus.in_valid = '0;
    chk("t2_addr0", bus.out_addr[63:0], 64'h103C);
    chk("t2_split", 64'(bus.out_split[0]), 64'd1);
    chk("t2_last0", 64'(bus.out_last[0]), 64'd0);
    repeat (5) begin
      step();
      chk("hold_addr", bus.out_addr[63:0], 64'h103C);
      chk("hold_ready", 64'(bus.in_ready[0]), 64'd0);
    end
    bus.out_ready = 2'b11;
    step();
    chk("t2_addr1", bus.out_addr[63:0], 64'h1040);
    chk("t2_beat1", 64'(bus.out_beat[0]), 64'd1);
    chk("t2_last1", 64'(bus.out_last[0]), 64'd1);
    step();
    chk("t2_idle", 64'(bus.out_valid[0]), 64'd0);
    repeat (20) begin
      for (int c = 0; c < 2; c++)
        set_op(c, 1'b1, 2'b01, {$urandom, $urandom} & ~64'h3F, 64'd0, 3'd0, 24'd0, 3'($urandom_range(0, 7)));
      step();
      chk("stream_ready", 64'(bus.in_ready), 64'd3);
    end
    bus.in_valid = '0;
    repeat (2) step();
    set_op(0, 1'b1, 2'b10, 64'hFFFF_FFFF_FFFF_FFF8, 64'h10, 3'($urandom), 24'($urandom), 3'd4);
    set_op(1, 1'b1, 2'b01, 64'hFFFF_FFFF_FFFF_FFFC, 64'd0, 3'd0, 24'd0, 3'd7);
    step();
    bus.in_valid = '0;
    chk("amo_addr", bus.out_addr[63:0], 64'h8);
    chk("amo_split", 64'(bus.out_split[0]), 64'd0);
    chk("wrap_addr0", bus.out_addr[127:64], 64'hFFFF_FFFF_FFFF_FFFC);
    chk("wrap_split", 64'(bus.out_split[1]), 64'd1);
    step();
    chk("wrap_addr1", bus.out_addr[127:64], 64'd0);
    chk("wrap_beat1", 64'(bus.out_beat[1]), 64'd1);
    step();
    bus.out_ready = 2'b00;
    set_op(0, 1'b1, 2'b01, 64'h203C, 64'd0, 3'd0, 24'd0, 3'd3);
    set_op(1, 1'b1, 2'b01, 64'h303E, 64'd0, 3'd0, 24'd0, 3'd2);
    step();
    bus.in_valid = '0;
    bus.out_ready = 2'b01;
    step();
    chk("fl_b1", 64'(bus.out_beat), 64'd1);
    chk("fl_valid_pre", 64'(bus.out_valid), 64'd3);
    set_op(0, 1'b1, 2'b01, 64'h4000, 64'd0, 3'd0, 24'd0, 3'd0);
    set_op(1, 1'b1, 2'b10, 64'h5000, 64'd8, 3'd0, 24'd0, 3'd0);
    flush_i = 1'b1;
    bus.out_ready = 2'b00;
    step();
    flush_i = 1'b0;
    bus.in_valid = '0;
    chk("fl_valid", 64'(bus.out_valid), 64'd0);
    step();
    chk("fl_noacc", 64'(bus.out_valid), 64'd0);
    set_op(0, 1'b1, 2'b01, 64'h603C, 64'd0, 3'd0, 24'd0, 3'd3);
    set_op(1, 1'b1, 2'b01, 64'h703F, 64'd0, 3'd0, 24'd0, 3'd1);
    step();
    bus.in_valid = '0;
    rst_ni = 1'b0;
    #1;
    chk("mid_rst_valid", 64'(bus.out_valid), 64'd0);
    chk("mid_rst_ready", 64'(bus.in_ready), 64'd0);
    chk("mid_rst_addr", bus.out_addr[127:64], 64'd0);
    chk("mid_rst_tag", 64'(bus.out_tag), 64'd0);
    chk("mid_rst_flags", 64'({bus.out_split, bus.out_beat, bus.out_last}), 64'd0);
    mq[0].delete();
    mq[1].delete();
    @(posedge clk_i);
    @(negedge clk_i);
    rst_ni = 1'b1;
    #1 chk("rel_ready", 64'(bus.in_ready), 64'd3);
    step();
    repeat (500) begin
      for (int c = 0; c < 2; c++) begin
        logic [63:0] a, b;
        a = {$urandom, $urandom};
        if ($urandom_range(0, 1) == 1) a[5:0] = 6'($urandom_range(56, 63));
        b = $urandom_range(0, 3) == 0 ? {$urandom, $urandom} : 64'($urandom_range(0, 255));
        set_op(c, 1'($urandom_range(0, 3) != 0),
               $urandom_range(0, 9) < 6 ? 2'b01 : 2'($urandom_range(0, 3)),
               a, b, 3'($urandom), 24'($urandom), 3'($urandom));
      end
      bus.out_ready = 2'($urandom_range(0, 3) == 0 ? $urandom : 3);
      flush_i = $urandom_range(0, 31) == 0;
      step();
    end
    bus.in_valid = '0;
    flush_i = 1'b0;
    bus.out_ready = 2'b11;
    repeat (4) step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/qupls_agen_mc.md
Name: qupls_agen_mc

Overview:
- Multi-channel, pipelined address generator that replaces the single-channel agen in the load/store path.
- Each channel accepts one memory op per handshake and computes base + scaled index + sign-extended displacement (or base + index for AMO).
- Emits one beat per cache line touched: an access that crosses a line produces a second beat addressed to the start of the next line.
- Results go to the TLB/DCache interface through a valid/ready handshake, with per-channel flush.

Parameters:
- NCH, 2, number of independent agen channels.
- AWID, 64, address width in bits.
- DISPW, 24, displacement field width; sign-extended to AWID.
- LINE_BITS, 6, log2 of cache line size in bytes (64-byte lines).
- TAGW, 8, width of the op tag carried through unchanged.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-low.
- flush  in  1  discard all pending work in every channel.
- in_valid  in  NCH  per-channel request valid.
- in_ready  out  NCH  per-channel request accepted when in_valid and in_ready are both high.
- in_mode  in  2*NCH  00 none, 01 load/store, 10 AMO, 11 none.
- in_a  in  AWID*NCH  base operand.
- in_b  in  AWID*NCH  index operand.
- in_sc  in  3*NCH  index left-shift amount, 0..7.
- in_disp  in  DISPW*NCH  displacement.
- in_size  in  3*NCH  log2 access bytes; 0..4 valid, 5..7 clamp to 4.
- in_tag  in  TAGW*NCH  op tag.
- out_valid  out  NCH  beat valid.
- out_ready  in  NCH  beat consumed when out_valid and out_ready are both high.
- out_addr  out  AWID*NCH  beat address.
- out_tag  out  TAGW*NCH  tag of the op that produced the beat.
- out_split  out  NCH  op crosses a line; constant across both beats.
- out_beat  out  NCH  0 = first beat, 1 = second beat.
- out_last  out  NCH  final beat of the op.

Behaviour:
- Per-channel FSM with states IDLE, B0, B1; channels are fully independent.
- Arithmetic, all modulo 2^AWID:
  - mode 01: addr = a + (b << sc) + sext(disp).
  - mode 10: addr = a + b; sc and disp ignored.
  - mode 00/11: addr = 0, split = 0.
- Line crossing: split = (addr[LINE_BITS-1:0] + 2^size - 1) >= 2^LINE_BITS, evaluated with the clamped size.
- Beat addresses:
  - Beat 0 carries addr.
  - Beat 1 carries {addr[AWID-1:LINE_BITS] + 1, LINE_BITS'b0}.
  - The line number wraps: all-ones + 1 gives 0.
- Latency: an op accepted in cycle N presents beat 0 in cycle N+1. Address and split are registered at acceptance and held stable while out_valid is high and out_ready is low.
- Transitions:
  - IDLE: accept → B0.
  - B0: out_ready and split → B1. out_ready and not split → accept ? B0 : IDLE.
  - B1: out_ready → accept ? B0 : IDLE.
- in_ready = not flush and (state == IDLE, or the current beat is last and out_ready is high this cycle). This gives back-to-back ops with no bubble.
- out_valid is high in B0/B1.
- out_last is high in B1, or in B0 when split = 0.
- out_beat = 1 only in B1.
- Flush:
  - All channels go to IDLE at the next edge; out_valid is low the cycle after flush.
  - in_ready is low during a flush cycle, so flush overrides a coincident accept.
  - A beat handshaken in the flush cycle still counts as consumed.
- Reset (rst low, asynchronous):
  - All FSMs go to IDLE; out_valid, out_split, out_beat, out_last = 0; out_addr, out_tag = 0; in_ready = 0 while in reset.
  - Reset mid-op drops the op with no residual beat.
  - in_ready rises in the first cycle after rst deasserts.

Test Plan:
- NCH=2, mode 01, a=0x1000, b=0x10, sc=3, disp=0xFFFFF8 (-8), size=3 → one beat next cycle: addr=0x1078, split=0, last=1.
- mode 01, a=0x103C, b=0, disp=0, size=3 (8 bytes at offset 60) → beat0 addr=0x103C split=1 last=0; after out_ready, beat1 addr=0x1040 beat=1 last=1.
- Hold out_ready=0 for 5 cycles on a split op → out_addr and out_tag stable, in_ready=0; release → beat1 then IDLE.
- Continuous in_valid and out_ready=1 with non-split ops on both channels → one beat per channel per cycle, in_ready never drops, tags in order.
- mode 10, a=0xFFFF_FFFF_FFFF_FFF8, b=0x10, size=4 → addr=0x8, split=0; separately, an op at line address all-ones with split → beat1 addr=0.
- Assert flush while channel 0 is in B1 and channel 1 is in B0 with in_valid high → both out_valid=0 the next cycle and no new op accepted. Repeat with rst pulsed low mid-op → all outputs 0 immediately, in_ready=1 the first cycle after release.
